// File: rtl/common_pkg.sv
// Shared machine-wide widths and data bus transaction types.
package common;

  localparam int XLEN = 64;

  typedef enum logic [2:0] {
    MSIZE1 = 3'd0,
    MSIZE2 = 3'd1,
    MSIZE4 = 3'd2,
    MSIZE8 = 3'd3
  } msize_t;

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] addr;
    msize_t          size;
    logic [7:0]      strobe;
    logic [XLEN-1:0] data;
  } dbus_req_t;

  typedef struct packed {
    logic            addr_ok;
    logic            data_ok;
    logic [XLEN-1:0] data;
  } dbus_resp_t;

endpackage

// File: rtl/mem_stage_pkg.sv
// Pipeline register payloads and MEM-stage types for the in-order RV64 core.
package pipes;
  import common::*;

  localparam logic [1:0] F3_B = 2'd0;
  localparam logic [1:0] F3_H = 2'd1;
  localparam logic [1:0] F3_W = 2'd2;
  localparam logic [1:0] F3_D = 2'd3;

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] alu_result;
    logic [XLEN-1:0] rs2_data;
    logic [4:0]      rd;
    logic            reg_write;
    logic            mem_read;
    logic            mem_write;
    logic [2:0]      funct3;
  } exec_data_t;

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] alu_result;
    logic [XLEN-1:0] rs2_data;
    logic [4:0]      rd;
    logic            reg_write;
    logic            mem_read;
    logic            mem_write;
    logic [2:0]      funct3;
    logic [XLEN-1:0] mem_rdata;
    logic            misalign;
  } mem_data_t;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } mem_state_t;

  // An access is aligned when the byte offset is a multiple of its size.
  function automatic logic is_misaligned(input logic [2:0] offset, input logic [1:0] size);
    case (size)
      F3_H:    return offset[0];
      F3_W:    return |offset[1:0];
      F3_D:    return |offset[2:0];
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mem_align.sv
// Byte-lane steering for data bus accesses: store strobe/data placement and
// load shift with sign/zero extension. Purely combinational.
module mem_align
  import common::*;
  import pipes::*;
(
  input  logic [2:0]      offset,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] store_data,
  input  logic [XLEN-1:0] load_data,
  output logic [7:0]      strobe,
  output logic [XLEN-1:0] wdata,
  output logic [XLEN-1:0] rdata,
  output logic            misalign
);

  logic [5:0]      shamt;
  logic [XLEN-1:0] rep;
  logic [XLEN-1:0] raw;
  logic            zext;

  assign shamt = {offset, 3'b000};
  assign zext  = funct3[2];
  assign raw   = load_data >> shamt;

  // Store data is replicated across the dword so every strobed lane carries it.
  always_comb begin
    rep    = '0;
    strobe = '0;
    rdata  = '0;
    case (funct3[1:0])
      F3_B: begin
        rep    = {8{store_data[7:0]}};
        strobe = 8'h01 << offset;
        rdata  = zext ? {56'b0, raw[7:0]} : {{56{raw[7]}}, raw[7:0]};
      end
      F3_H: begin
        rep    = {4{store_data[15:0]}};
        strobe = 8'h03 << offset;
        rdata  = zext ? {48'b0, raw[15:0]} : {{48{raw[15]}}, raw[15:0]};
      end
      F3_W: begin
        rep    = {2{store_data[31:0]}};
        strobe = 8'h0F << offset;
        rdata  = zext ? {32'b0, raw[31:0]} : {{32{raw[31]}}, raw[31:0]};
      end
      default: begin
        rep    = store_data;
        strobe = 8'hFF << offset;
        rdata  = raw;
      end
    endcase
  end

  assign wdata    = rep << shamt;
  assign misalign = is_misaligned(offset, funct3[1:0]);

endmodule

// File: rtl/mem_stage.sv
// MEM stage: issues one data bus request per memory instruction, holds the
// result in DONE until the pipeline can advance, and builds the MEM/WB payload.
module mem_stage
  import common::*;
  import pipes::*;
(
  input  logic       clk,
  input  logic       reset,
  input  exec_data_t dataE,
  input  logic       stall_in,
  output dbus_req_t  dreq,
  input  dbus_resp_t dresp,
  output mem_data_t  dataM,
  output logic       mem_stall
);

  mem_state_t      state;
  logic [XLEN-1:0] rbuf;
  logic [XLEN-1:0] load_value;
  logic [XLEN-1:0] wdata;
  logic [7:0]      strobe;
  logic            align_fault;
  logic            is_access;
  logic            misalign;
  logic            mem_op;
  logic            req_active;
  logic            unused_bits;

  mem_align u_align (
    .offset     (dataE.alu_result[2:0]),
    .funct3     (dataE.funct3),
    .store_data (dataE.rs2_data),
    .load_data  (dresp.data),
    .strobe     (strobe),
    .wdata      (wdata),
    .rdata      (load_value),
    .misalign   (align_fault)
  );

  assign is_access  = dataE.valid & (dataE.mem_read | dataE.mem_write);
  assign misalign   = is_access & align_fault;
  assign mem_op     = is_access & ~align_fault;
  assign req_active = mem_op & (state != DONE);
  assign mem_stall  = req_active;

  // The bus slave accepts address and data together; addr_ok carries no extra meaning here.
  assign unused_bits = dresp.addr_ok;

  // Request fields depend only on the held dataE, so they stay bit-stable in BUSY.
  always_comb begin
    dreq = '0;
    if (req_active) begin
      dreq.valid = 1'b1;
      dreq.addr  = {dataE.alu_result[XLEN-1:3], 3'b000};
      dreq.size  = msize_t'({1'b0, dataE.funct3[1:0]});
      if (dataE.mem_write) begin
        dreq.strobe = strobe;
        dreq.data   = wdata;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      rbuf  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (mem_op) begin
            if (dresp.data_ok) begin
              rbuf  <= load_value;
              state <= DONE;
            end else begin
              state <= BUSY;
            end
          end
        end
        BUSY: begin
          if (dresp.data_ok) begin
            rbuf  <= load_value;
            state <= DONE;
          end
        end
        DONE: begin
          if (!stall_in) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    dataM            = '0;
    dataM.valid      = dataE.valid;
    dataM.pc         = dataE.pc;
    dataM.alu_result = dataE.alu_result;
    dataM.rs2_data   = dataE.rs2_data;
    dataM.rd         = dataE.rd;
    dataM.reg_write  = dataE.reg_write;
    dataM.mem_read   = dataE.mem_read;
    dataM.mem_write  = dataE.mem_write;
    dataM.funct3     = dataE.funct3;
    dataM.mem_rdata  = (state == DONE) ? rbuf : '0;
    dataM.misalign   = misalign;
  end

endmodule

// File: tb/tb_mem_stage.sv
// Randomised self-checking bench for mem_stage with a byte-level reference model.
module tb_mem_stage;
  import common::*;
  import pipes::*;

  logic       clk = 1'b0;
  logic       reset;
  exec_data_t dataE;
  logic       stall_in;
  dbus_req_t  dreq;
  dbus_resp_t dresp;
  mem_data_t  dataM;
  logic       mem_stall;

  int tests_run  = 0;
  int fail_count = 0;

  always #5 clk = ~clk;

  mem_stage dut (
    .clk       (clk),
    .reset     (reset),
    .dataE     (dataE),
    .stall_in  (stall_in),
    .dreq      (dreq),
    .dresp     (dresp),
    .dataM     (dataM),
    .mem_stall (mem_stall)
  );

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      fail_count++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  function automatic int access_bytes(input logic [2:0] f3);
    return 1 << f3[1:0];
  endfunction

  // Picks the addressed bytes out of the dword and extends them.
  function automatic logic [63:0] model_load(input logic [63:0] dword, input logic [2:0] off,
                                             input logic [2:0] f3);
    int n = access_bytes(f3);
    logic [63:0] v = '0;
    for (int i = 0; i < n; i++) v[8*i +: 8] = dword[8*(int'(off)+i) +: 8];
    if (!f3[2] && n < 8 && v[8*n-1])
      for (int i = n; i < 8; i++) v[8*i +: 8] = 8'hFF;
    return v;
  endfunction

  function automatic logic [7:0] model_strobe(input logic [2:0] off, input logic [2:0] f3);
    logic [7:0] s = '0;
    for (int i = 0; i < access_bytes(f3); i++) s[int'(off)+i] = 1'b1;
    return s;
  endfunction

  function automatic logic [63:0] lane_mask(input logic [7:0] s);
    logic [63:0] m = '0;
    for (int i = 0; i < 8; i++) if (s[i]) m[8*i +: 8] = 8'hFF;
    return m;
  endfunction

  function automatic logic [63:0] model_store_lanes(input logic [63:0] rs2, input logic [2:0] off,
                                                    input logic [2:0] f3);
    logic [63:0] d = '0;
    for (int i = 0; i < access_bytes(f3); i++) d[8*(int'(off)+i) +: 8] = rs2[8*i +: 8];
    return d;
  endfunction

  function automatic exec_data_t mk(input logic rd_op, input logic wr_op, input logic [2:0] f3,
                                    input logic [63:0] addr, input logic [63:0] rs2);
    exec_data_t e;
    e            = '0;
    e.valid      = 1'b1;
    e.pc         = {$urandom, $urandom};
    e.alu_result = addr;
    e.rs2_data   = rs2;
    e.rd         = 5'($urandom_range(1, 31));
    e.reg_write  = ~wr_op;
    e.mem_read   = rd_op;
    e.mem_write  = wr_op;
    e.funct3     = f3;
    return e;
  endfunction

  // Runs one instruction through the stage with bus latency lat and hold DONE-stall cycles.
  task automatic applyStimulus(input exec_data_t e, input int lat, input logic [63:0] dword,
                               input int hold);
    logic [2:0]  off    = e.alu_result[2:0];
    int          n      = access_bytes(e.funct3);
    logic        is_acc = e.valid && (e.mem_read || e.mem_write);
    logic        mis    = is_acc && ((int'(off) % n) != 0);
    logic        op     = is_acc && !mis;
    logic [7:0]  exp_strb;
    logic [63:0] mask;
    @(negedge clk);
    dataE    = e;
    stall_in = 1'b0;
    dresp    = '0;
    if (!op) begin
      #1;
      checkOutput("pass_dreq_valid", 64'(dreq.valid), 64'(0));
      checkOutput("pass_stall", 64'(mem_stall), 64'(0));
      checkOutput("pass_valid", 64'(dataM.valid), 64'(e.valid));
      checkOutput("pass_alu", dataM.alu_result, e.alu_result);
      checkOutput("pass_pc", dataM.pc, e.pc);
      checkOutput("pass_rd", 64'(dataM.rd), 64'(e.rd));
      checkOutput("pass_rdata", dataM.mem_rdata, 64'(0));
      checkOutput("pass_misalign", 64'(dataM.misalign), 64'(mis));
      @(posedge clk);
      return;
    end
    exp_strb = model_strobe(off, e.funct3);
    mask     = lane_mask(exp_strb);
    for (int c = 0; c <= lat; c++) begin
      if (c > 0) @(negedge clk);
      dresp.addr_ok = (c == 0);
      dresp.data_ok = (c == lat);
      dresp.data    = (c == lat) ? dword : {$urandom, $urandom};
      #1;
      checkOutput("req_stall", 64'(mem_stall), 64'(1));
      checkOutput("req_valid", 64'(dreq.valid), 64'(1));
      checkOutput("req_addr", dreq.addr, {e.alu_result[63:3], 3'b000});
      checkOutput("req_size", 64'(dreq.size), 64'(e.funct3[1:0]));
      checkOutput("req_misalign", 64'(dataM.misalign), 64'(0));
      if (e.mem_write) begin
        checkOutput("req_strobe", 64'(dreq.strobe), 64'(exp_strb));
        checkOutput("req_wdata", dreq.data & mask, model_store_lanes(e.rs2_data, off, e.funct3));
      end
      @(posedge clk);
    end
    for (int h = 0; h <= hold; h++) begin
      @(negedge clk);
      stall_in = (h < hold);
      dresp    = '0;
      dresp.data = {$urandom, $urandom};
      #1;
      checkOutput("done_stall", 64'(mem_stall), 64'(0));
      checkOutput("done_dreq_valid", 64'(dreq.valid), 64'(0));
      checkOutput("done_valid", 64'(dataM.valid), 64'(1));
      if (e.mem_read)
        checkOutput("done_rdata", dataM.mem_rdata, model_load(dword, off, e.funct3));
      @(posedge clk);
    end
  endtask

  initial begin
    exec_data_t e;
    logic [63:0] addr;
    int kind;
    logic [2:0] f3;

    reset    = 1'b1;
    dataE    = '0;
    stall_in = 1'b0;
    dresp    = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    checkOutput("rst_dreq_valid", 64'(dreq.valid), 64'(0));
    checkOutput("rst_dreq_addr", dreq.addr, 64'(0));
    checkOutput("rst_dreq_strobe", 64'(dreq.strobe), 64'(0));
    checkOutput("rst_dreq_data", dreq.data, 64'(0));
    checkOutput("rst_stall", 64'(mem_stall), 64'(0));
    checkOutput("rst_dataM_valid", 64'(dataM.valid), 64'(0));
    checkOutput("rst_rdata", dataM.mem_rdata, 64'(0));
    reset = 1'b0;
    @(posedge clk);

    applyStimulus(mk(1'b0, 1'b0, 3'd0, 64'h1234, 64'h55), 0, 64'h0, 0);
    applyStimulus(mk(1'b1, 1'b0, 3'd0, 64'h1003, 64'h0), 2, 64'h0000_0000_80FF_0000, 0);
    applyStimulus(mk(1'b1, 1'b0, 3'd6, 64'h1004, 64'h0), 1, 64'h8765_4321_0000_0000, 0);
    applyStimulus(mk(1'b1, 1'b0, 3'd2, 64'h1004, 64'h0), 0, 64'h8765_4321_0000_0000, 0);
    applyStimulus(mk(1'b0, 1'b1, 3'd1, 64'h2006, 64'hBEEF), 3, 64'h0, 0);
    applyStimulus(mk(1'b1, 1'b0, 3'd3, 64'h3004, 64'h0), 0, 64'h0, 0);
    applyStimulus(mk(1'b1, 1'b0, 3'd3, 64'h3008, 64'h0), 1, 64'hCAFE_F00D_1234_5678, 4);

    // Reset arriving while the access is outstanding abandons it.
    @(negedge clk);
    dataE = mk(1'b1, 1'b0, 3'd3, 64'h4000, 64'h0);
    dresp = '0;
    @(posedge clk);
    @(negedge clk);
    #1;
    checkOutput("busy_stall", 64'(mem_stall), 64'(1));
    reset = 1'b1;
    dataE = '0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    checkOutput("abort_stall", 64'(mem_stall), 64'(0));
    checkOutput("abort_dreq_valid", 64'(dreq.valid), 64'(0));
    checkOutput("abort_rdata", dataM.mem_rdata, 64'(0));
    @(posedge clk);
    applyStimulus(mk(1'b1, 1'b0, 3'd4, 64'h5005, 64'h0), 0, 64'h0000_9A00_0000_0000, 1);

    for (int t = 0; t < 40; t++) begin
      kind = $urandom_range(0, 2);
      addr = {$urandom, $urandom};
      if (kind == 2) f3 = 3'($urandom_range(0, 3));
      else           f3 = 3'($urandom_range(0, 6));
      if ($urandom_range(0, 3) != 0) addr[2:0] = addr[2:0] & ~3'(access_bytes(f3) - 1);
      e = mk(kind == 1, kind == 2, f3, addr, {$urandom, $urandom});
      if ($urandom_range(0, 7) == 0) e.valid = 1'b0;
      applyStimulus(e, $urandom_range(0, 3), {$urandom, $urandom}, $urandom_range(0, 2));
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, fail_count);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access stage of the in-order RV64 pipeline. Consumes the EX/MEM register output, performs loads and stores over the data bus with a small handshake FSM, and aligns and extends load data. Produces the MEM/WB payload and a stall request to the hazard unit. Non-memory instructions pass through in zero cycles.

## Interface
- Parameters: none; widths come from `common` (XLEN = 64).
- `clk` in 1: pipeline clock.
- `reset` in 1: synchronous, active-high.
- `dataE` in `exec_data_t`: EX/MEM payload. Consumed fields:
  - `valid`
  - `alu_result` (address)
  - `rs2_data` (store data)
  - `mem_read`, `mem_write`
  - `funct3` (3-bit access size/sign)
  - remaining fields forwarded unchanged.
- `stall_in` in 1: downstream/hazard hold; result must be kept.
- `dreq` out `dbus_req_t`:
  - `valid` 1
  - `addr` 64
  - `size` 3 (`msize_t`)
  - `strobe` 8
  - `data` 64
- `dresp` in `dbus_resp_t`:
  - `addr_ok` 1
  - `data_ok` 1
  - `data` 64
- `dataM` out `mem_data_t`: `dataE` fields plus `mem_rdata` 64 and `misalign` 1.
- `mem_stall` out 1: high while an access is incomplete.

## Operation
- `mem_op = dataE.valid & (mem_read | mem_write) & ~misalign`.
- Misalign: `addr` not aligned to the access size (H: bit0; W: bits[1:0]; D: bits[2:0]).
  - No bus request is issued.
  - `dataM.misalign = 1`, `mem_stall = 0`.
- FSM states: IDLE, BUSY, DONE. Reset state is IDLE.
  - IDLE, `mem_op`: drive request. If `data_ok` arrives the same cycle, go to DONE; otherwise go to BUSY.
  - BUSY: hold `dreq` bit-stable. On `data_ok`, capture the lane-shifted `dresp.data` into `rbuf` and go to DONE. `addr_ok` is ignored beyond the bus contract.
  - DONE, `stall_in = 0`: go to IDLE.
  - DONE, `stall_in = 1`: stay in DONE.
- `dreq.valid = mem_op & (state != DONE)`. `dreq.addr = {alu_result[63:3], 3'b0}`.
- Stores:
  - `size` from `funct3[1:0]`.
  - `strobe = ({B:8'h01, H:8'h03, W:8'h0F, D:8'hFF}) << addr[2:0]`.
  - `data = rs2_data << (addr[2:0]*8)`, with the low bytes replicated per size.
- Loads:
  - `raw = dresp.data >> (addr[2:0]*8)`.
  - Extend sign or zero by `funct3[2]` (LBU/LHU/LWU are zero-extend).
  - LD uses `raw` unchanged.
- `mem_stall = mem_op & (state != DONE)`.
- `dataM` is combinational:
  - `dataE` fields forwarded.
  - `mem_rdata = rbuf` in DONE, 0 otherwise.
  - `dataM.valid` follows `dataE.valid`.
- Stores also pass through BUSY/DONE; `rbuf` is don't-care for them.

## Timing
- Reset values:
  - state IDLE, `rbuf` 0.
  - `dreq` all 0 when `dataE` is the reset bubble.
  - `mem_stall` 0.
  - `dataM` = `'0`-derived (valid 0).
- Non-memory or misaligned instruction: 0 added cycles.
- Memory op with bus latency L (cycles from first `dreq.valid` to `data_ok`, L ≥ 0):
  - `mem_stall` is high for L+1 cycles.
  - The result is visible in the DONE cycle.
  - The EX/MEM register advances at the end of DONE.
- `stall_in` in BUSY: the transaction still completes. The FSM stays in DONE with the result held until `stall_in` drops.
- A request is never re-issued for the same instruction; DONE blocks it.
- Reset mid-transaction: FSM returns to IDLE and the outstanding access is abandoned. The bus slave is reset by the same `reset`.
- `dataE` must be held stable while `mem_stall = 1`. The hazard unit guarantees this by stalling EX/MEM.

## Structure
- `pipes` package:
  - `mem_data_t`
  - `mem_state_t` enum {IDLE, BUSY, DONE}
  - funct3 size constants.
- `common`: `dbus_req_t`, `dbus_resp_t`, `msize_t`.
- Sub-module `mem_align` (combinational): produces store strobe/data and load shift/extend from `addr[2:0]`, `funct3`, and data. It is reusable by the future MMIO path. `mem_stage` holds the FSM and `rbuf`.

## Test plan
- ADD, `dataE.valid = 1`, no mem op → `dreq.valid = 0`, `mem_stall = 0`, `dataM` equals `dataE` with `mem_rdata = 0`, same cycle.
- LB at addr `0x1003`, memory dword `0x0000_0000_80FF_0000` → `rdata = 0xFFFF_FFFF_FFFF_FF80`. With L = 2, `mem_stall` is high for 3 cycles.
- LWU at `0x1004`, dword `0x8765_4321_0000_0000` → `rdata = 0x0000_0000_8765_4321`. LW on the same data → `0xFFFF_FFFF_8765_4321`.
- SH `rs2 = 0xBEEF` at `0x2006` → `strobe = 8'hC0`, `data[63:48] = 0xBEEF`. `dreq` stays stable across 3 wait cycles.
- LD at `0x3004` → `misalign = 1`, no `dreq.valid`, `mem_stall = 0`.
- LD with `stall_in = 1` for 4 cycles after `data_ok` → stays in DONE, `rdata` held, exactly one `dreq` issued. A reset asserted in BUSY → next cycle IDLE, `mem_stall = 0`.
